// File: rtl/coarse_count_reader.sv
// Consumer for coarse-counter results: edge-detects the valid strobe, tags each
// count and buffers {tag,count} in a FIFO, counting results lost on overflow.
module coarse_count_reader #(
   parameter int CNT_W = 12,
   parameter int TAG_W = 4,
   parameter int DEPTH = 16,
   parameter int OVF_W = 8
) (
   input  logic                     clk_CR,
   input  logic                     reset_CR,
   input  logic                     clear_CR,
   input  logic                     valid_in_CR,
   input  logic [CNT_W-1:0]         count_in_CR,
   input  logic                     rd_en_CR,
   output logic [TAG_W+CNT_W-1:0]   data_out_CR,
   output logic                     data_valid_CR,
   output logic                     empty_CR,
   output logic                     full_CR,
   output logic [$clog2(DEPTH):0]   level_CR,
   output logic [OVF_W-1:0]         ovf_cnt_CR
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = TAG_W + CNT_W;
   localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);
   localparam logic [OVF_W-1:0] OVF_ONE  = OVF_W'(1);

   logic [DW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             valid_d;
   logic [TAG_W-1:0] tag;
   logic [DW-1:0]    cap_reg;
   logic             cap_vld;

   logic             event_det;
   logic             rd_ok;
   logic             wr_ok;
   logic             drop;
   logic [AW:0]      level_nxt;

   // Event, read/write acceptance and next FIFO occupancy
   always_comb begin
      event_det = valid_in_CR & ~valid_d;
      rd_ok     = rd_en_CR & ~empty_CR;
      wr_ok     = cap_vld & (~full_CR | rd_ok);
      drop      = cap_vld & full_CR & ~rd_ok;
      level_nxt = level_CR;
      unique case ({wr_ok, rd_ok})
         2'b10:   level_nxt = level_CR + LVL_ONE;
         2'b01:   level_nxt = level_CR - LVL_ONE;
         default: level_nxt = level_CR;
      endcase
   end

   // FIFO storage; contents need no reset since level gates every read
   always_ff @(posedge clk_CR) begin
      if (wr_ok && !clear_CR)
         mem[wr_ptr] <= cap_reg;
   end

   // Capture, pointers, flags, readout and overflow counter
   always_ff @(posedge clk_CR or posedge reset_CR) begin
      if (reset_CR) begin
         valid_d       <= 1'b0;
         tag           <= '0;
         cap_reg       <= '0;
         cap_vld       <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level_CR      <= '0;
         empty_CR      <= 1'b1;
         full_CR       <= 1'b0;
         data_out_CR   <= '0;
         data_valid_CR <= 1'b0;
         ovf_cnt_CR    <= '0;
      end else if (clear_CR) begin
         valid_d       <= valid_in_CR;
         tag           <= '0;
         cap_reg       <= '0;
         cap_vld       <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level_CR      <= '0;
         empty_CR      <= 1'b1;
         full_CR       <= 1'b0;
         data_out_CR   <= '0;
         data_valid_CR <= 1'b0;
         ovf_cnt_CR    <= '0;
      end else begin
         valid_d <= valid_in_CR;
         cap_vld <= event_det;
         if (event_det) begin
            cap_reg <= {tag, count_in_CR};
            tag     <= tag + TAG_ONE;
         end
         if (wr_ok)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) begin
            rd_ptr      <= rd_ptr + PTR_ONE;
            data_out_CR <= mem[rd_ptr];
         end
         data_valid_CR <= rd_ok;
         level_CR      <= level_nxt;
         empty_CR      <= (level_nxt == '0);
         full_CR       <= (level_nxt == LVL_FULL);
         if (drop && !(&ovf_cnt_CR))
            ovf_cnt_CR <= ovf_cnt_CR + OVF_ONE;
      end
   end

endmodule
